// File: rtl/tx_sequence_generator_pkg.sv
// tx_pkg: shared sequence constants, G2 seed table and FSM state encoding
package tx_pkg;
  localparam int N_CHIPS = 1023;
  localparam int SAMPLES_PER_CHIP = 16;
  localparam int N_SAMPLES = N_CHIPS * SAMPLES_PER_CHIP;
  // bit i is LFSR stage i+1; all entries nonzero so G2 never locks up
  localparam logic [9:0] GOLD_SEED [16] = '{
    10'h3A5, 10'h1C7, 10'h2F0, 10'h0B3, 10'h36E, 10'h15D, 10'h289, 10'h07A,
    10'h3C1, 10'h114, 10'h2D6, 10'h0E9, 10'h1F2, 10'h34B, 10'h0C5, 10'h26F
  };
  typedef enum logic [1:0] {IDLE, ARM, SEND, DONE} state_e;
endpackage

// File: rtl/tx_gold_code_gen.sv
// tx_gold_code_gen: G1/G2 Fibonacci LFSR pair producing one Gold-code chip
module tx_gold_code_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [9:0] seed,
  input  logic       advance,
  output logic       chip
);
  logic [9:0] g1_q, g2_q;
  logic       fb1, fb2;
  assign fb1  = g1_q[2] ^ g1_q[9];
  assign fb2  = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];
  assign chip = g1_q[9] ^ g2_q[9];
  always_ff @(posedge clk) begin
    if (rst) begin
      g1_q <= '1;
      g2_q <= '1;
    end else if (load) begin
      g1_q <= '1;
      g2_q <= seed;
    end else if (advance) begin
      g1_q <= {g1_q[8:0], fb1};
      g2_q <= {g2_q[8:0], fb2};
    end
  end
endmodule

// File: rtl/tx_sequence_generator.sv
// tx_sequence_generator: start-triggered BPSK Gold-code sample stream with tx timestamp
module tx_sequence_generator
  import tx_pkg::*;
#(
  parameter logic signed [15:0] AMP = 16'sd8192
) (
  input  logic               ctx_clk,
  input  logic               rtx_rst,
  input  logic               etx_en,
  input  logic [31:0]        icurrent_time,
  input  logic               inew_sample_trigger,
  input  logic               istart,
  input  logic [3:0]         iseq_select,
  output logic signed [15:0] o_sample,
  output logic               o_sample_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [3:0]         o_seq,
  output logic [31:0]        o_tx_time
);
  state_e             state_q;
  logic [13:0]        s_q;
  logic signed [15:0] sample_q, sample_d, carrier;
  logic               valid_q, busy_q, done_q, chip, active, last, clr;
  logic [3:0]         seq_q;
  logic [31:0]        tx_time_q;
  assign clr     = rtx_rst || !etx_en;
  assign active  = (state_q == ARM || state_q == SEND) && inew_sample_trigger;
  assign last    = s_q == 14'(N_SAMPLES - 1);
  assign carrier = s_q[0] ? (s_q[1] ? -AMP : AMP) : 16'sd0;
  assign sample_d = chip ? carrier : -carrier;
  tx_gold_code_gen u_gold (
    .clk     (ctx_clk),
    .rst     (clr),
    .load    (state_q == IDLE && istart),
    .seed    (GOLD_SEED[iseq_select]),
    .advance (active && s_q[3:0] == 4'(SAMPLES_PER_CHIP - 1)),
    .chip    (chip)
  );
  always_ff @(posedge ctx_clk) begin
    if (clr) begin
      state_q   <= IDLE;
      s_q       <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seq_q     <= '0;
      tx_time_q <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (istart) begin
          seq_q   <= iseq_select;
          s_q     <= '0;
          busy_q  <= 1'b1;
          state_q <= ARM;
        end
        ARM, SEND: if (inew_sample_trigger) begin
          sample_q <= sample_d;
          valid_q  <= 1'b1;
          s_q      <= last ? s_q : s_q + 14'd1;
          if (state_q == ARM) tx_time_q <= icurrent_time;
          state_q  <= last ? DONE : SEND;
        end
        default: begin
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          sample_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end
  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_seq          = seq_q;
  assign o_tx_time      = tx_time_q;
endmodule
